rx_buf_writer: RTL

Packs per-channel 24-bit I/Q samples from the receiver channel mux into 16-bit words and writes them into the dual-clock receive sample BRAM on its write port (clka/addra/dina/wea). The BRAM is split into two halves, ping and pong. When one half fills, the block flips to the other half, notifies the CPU-side reader and tracks overruns. It runs entirely in the ADC clock domain.

---
 rtl/rx_buf_writer.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/rx_buf_writer.sv
// rx_buf_writer: packs 24-bit I/Q samples into 16-bit words for the
// receive-sample BRAM write port, ping/pong halves, with overrun tracking.
// Ports: adc_clk/reset_n (clock, async active-low reset), run (capture
// enable), in_valid/in_ready/in_i/in_q (sample input), buf_ack/ovr_clr
// (CPU-side pulses), addra/dina/wea (BRAM port A), buf_done/buf_half
// (half-complete pulse and index), overrun (sticky).
// Optional macro RXBUF_TICKS_EN appends a 48-bit adc_clk timestamp to
// every half, latched at the accept of that half's last sample.
module rx_buf_writer #(
    parameter int ADDR_MSB = 13,
    parameter int NRX      = 4,
    parameter int NSAMPS   = 170
) (
    input  logic              adc_clk,
    input  logic              reset_n,
    input  logic              run,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [23:0]       in_i,
    input  logic [23:0]       in_q,
    input  logic              buf_ack,
    input  logic              ovr_clr,
    output logic [ADDR_MSB:0] addra,
    output logic [15:0]       dina,
    output logic              wea,
    output logic              buf_done,
    output logic              buf_half,
    output logic              overrun
);

`ifdef RXBUF_TICKS_EN
    localparam int TICK_WORDS = 3;
`else
    localparam int TICK_WORDS = 0;
`endif
    localparam int SPH        = NRX * NSAMPS;
    localparam int HALF_WORDS = SPH * 3 + TICK_WORDS;
    localparam logic [ADDR_MSB-1:0] LAST_OFF = ADDR_MSB'(HALF_WORDS - 1);
    localparam logic [ADDR_MSB-1:0] OFF_ONE  = ADDR_MSB'(1);

    if (HALF_WORDS > (1 << ADDR_MSB)) begin : g_size_chk
        $error("rx_buf_writer: half size exceeds 2^ADDR_MSB words");
    end

    typedef enum logic [2:0] {
        IDLE,
        W0,
        W1,
        W2
`ifdef RXBUF_TICKS_EN
        ,
        T0,
        T1,
        T2
`endif
    } state_t;

    state_t              state;
    state_t              st_n;
    logic                wr_n;
    logic [15:0]         wd_n;
    logic                ready_n;
    logic                clr_n;
    logic                accept;
    logic                last_wr_n;
    logic                tick_block;

    logic                half;
    logic [ADDR_MSB-1:0] offset;
    logic                pending;
    logic                last_wr;
    logic [15:0]         hold_q_lo;
    logic [15:0]         hold_hi;

    assign accept = in_valid & in_ready;

`ifdef RXBUF_TICKS_EN
    localparam logic [ADDR_MSB-1:0] LAST_SAMP = ADDR_MSB'(SPH - 1);

    logic [47:0]         tick_cnt;
    logic [47:0]         tick_q;
    logic [ADDR_MSB-1:0] samp_cnt;
    logic                last_samp;

    // The last sample of a half is followed by the timestamp words,
    // so no new sample may be taken during its W2.
    assign tick_block = last_samp;

    always_ff @(posedge adc_clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt  <= '0;
            tick_q    <= '0;
            samp_cnt  <= '0;
            last_samp <= 1'b0;
        end else begin
            tick_cnt <= tick_cnt + 48'd1;
            if (accept) begin
                last_samp <= (samp_cnt == LAST_SAMP);
                if (samp_cnt == LAST_SAMP) begin
                    samp_cnt <= '0;
                    tick_q   <= tick_cnt;
                end else begin
                    samp_cnt <= samp_cnt + OFF_ONE;
                end
            end else if (clr_n) begin
                samp_cnt <= '0;
            end
        end
    end
`else
    assign tick_block = 1'b0;
`endif

    // Next-state and next-word selection. The state names the word
    // currently on the BRAM port; each state issues the following word.
    always_comb begin
        st_n = state;
        wr_n = 1'b0;
        wd_n = '0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    st_n = W0;
                    wr_n = 1'b1;
                    wd_n = in_i[15:0];
                end
            end
            W0: begin
                st_n = W1;
                wr_n = 1'b1;
                wd_n = hold_q_lo;
            end
            W1: begin
                st_n = W2;
                wr_n = 1'b1;
                wd_n = hold_hi;
            end
            W2: begin
`ifdef RXBUF_TICKS_EN
                if (last_samp) begin
                    st_n = T0;
                    wr_n = 1'b1;
                    wd_n = tick_q[15:0];
                end else if (accept) begin
                    st_n = W0;
                    wr_n = 1'b1;
                    wd_n = in_i[15:0];
                end else begin
                    st_n = IDLE;
                end
`else
                if (accept) begin
                    st_n = W0;
                    wr_n = 1'b1;
                    wd_n = in_i[15:0];
                end else begin
                    st_n = IDLE;
                end
`endif
            end
`ifdef RXBUF_TICKS_EN
            T0: begin
                st_n = T1;
                wr_n = 1'b1;
                wd_n = tick_q[31:16];
            end
            T1: begin
                st_n = T2;
                wr_n = 1'b1;
                wd_n = tick_q[47:32];
            end
            T2: begin
                st_n = IDLE;
            end
`endif
            default: begin
                st_n = IDLE;
            end
        endcase
    end

    assign ready_n   = run & ((st_n == IDLE) |
                              ((st_n == W2) & ~tick_block));
    // Dropping to IDLE with run low abandons the partial half.
    assign clr_n     = (st_n == IDLE) & ~run;
    assign last_wr_n = wr_n & (offset == LAST_OFF);

    always_ff @(posedge adc_clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            addra     <= '0;
            dina      <= '0;
            wea       <= 1'b0;
            buf_done  <= 1'b0;
            buf_half  <= 1'b0;
            overrun   <= 1'b0;
            half      <= 1'b0;
            offset    <= '0;
            pending   <= 1'b0;
            last_wr   <= 1'b0;
            hold_q_lo <= '0;
            hold_hi   <= '0;
        end else begin
            state    <= st_n;
            in_ready <= ready_n;
            wea      <= wr_n;
            last_wr  <= last_wr_n;
            buf_done <= last_wr;

            if (accept) begin
                hold_q_lo <= in_q[15:0];
                hold_hi   <= {in_i[23:16], in_q[23:16]};
            end

            // The half bit flips as the last word is issued so that a
            // sample accepted in the same W2 lands in the new half.
            if (wr_n) begin
                addra <= {half, offset};
                dina  <= wd_n;
                if (last_wr_n) begin
                    offset <= '0;
                    half   <= ~half;
                end else begin
                    offset <= offset + OFF_ONE;
                end
            end else if (clr_n) begin
                offset <= '0;
                half   <= 1'b0;
            end

            if (last_wr) begin
                buf_half <= ~half;
            end

            // Ack clears first; a completion in the same cycle re-arms.
            if (buf_ack || clr_n) begin
                pending <= 1'b0;
            end
            if (last_wr) begin
                pending <= 1'b1;
            end

            if (ovr_clr) begin
                overrun <= 1'b0;
            end
            if (last_wr && pending && !buf_ack) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule
